// File: rtl/bu_pkg.sv
// ---------------------------------------------------------------------------
// bu_pkg
// Shared definitions for the L1 bus-unit arbiter slice.
//   - Requester index constants (bit positions in req/gnt/done/err and the
//     encoded value driven on sel).
//   - Arbiter FSM state encoding.
// ---------------------------------------------------------------------------
package bu_pkg;

   localparam logic [1:0] BU_REQ_D   = 2'd0;
   localparam logic [1:0] BU_REQ_I   = 2'd1;
   localparam logic [1:0] BU_REQ_PTW = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } bu_state_t;

endpackage

// File: rtl/bu_rr_pick.sv
// ---------------------------------------------------------------------------
// bu_rr_pick
// Combinational winner selection for the bus-unit arbiter.
// Priority: starved I/PTW requester(s) first, then D, then I/PTW by the
// round-robin pointer.
// Ports:
//   req     in  3  level requests (bit0 D, bit1 I, bit2 PTW)
//   starve  in  2  starvation flags (bit0 I, bit1 PTW)
//   ptr     in  1  I/PTW round-robin pointer (0 = I next)
//   win     out 3  one-hot winner, 0 when no request
//   idx     out 2  encoded winner, BU_REQ_D when no request
// ---------------------------------------------------------------------------
module bu_rr_pick
   import bu_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] starve,
   input  logic       ptr,
   output logic [2:0] win,
   output logic [1:0] idx
);

   logic force_i;
   logic force_p;

   always_comb begin
      win     = 3'b000;
      idx     = BU_REQ_D;
      force_i = req[BU_REQ_I]   & starve[0];
      force_p = req[BU_REQ_PTW] & starve[1];

      if (force_i && force_p) begin
         idx = ptr ? BU_REQ_PTW : BU_REQ_I;
      end else if (force_i) begin
         idx = BU_REQ_I;
      end else if (force_p) begin
         idx = BU_REQ_PTW;
      end else if (req[BU_REQ_D]) begin
         idx = BU_REQ_D;
      end else if (req[BU_REQ_I] && req[BU_REQ_PTW]) begin
         idx = ptr ? BU_REQ_PTW : BU_REQ_I;
      end else if (req[BU_REQ_I]) begin
         idx = BU_REQ_I;
      end else if (req[BU_REQ_PTW]) begin
         idx = BU_REQ_PTW;
      end

      if (|req) begin
         win = 3'b001 << idx;
      end
   end

endmodule

// File: rtl/bu_arbiter.sv
// ---------------------------------------------------------------------------
// bu_arbiter
// Shares the single L1 bus unit between L1-D (bit0), L1-I (bit1) and the
// page-table walker (bit2). One owner at a time; the grant is held until the
// bus unit reports completion or error, then dropped for one RELEASE cycle.
// D wins by default; I and PTW are forced through after STARVE_MAX lost
// arbitrations.
//
// Optional feature (macro BU_ARB_TIMEOUT_EN): abort a grant after
// TIMEOUT_CYC cycles without completion, pulsing err[owner] and abort.
//
// Ports:
//   clk        in   1  clock
//   rst        in   1  synchronous active-high reset
//   req        in   3  level requests, held until done/err
//   gnt        out  3  registered one-hot grant
//   sel        out  2  encoded owner (0 when idle) for the bus request mux
//   bus_req    out  1  |gnt
//   trans_rdy  in   1  bus-unit transfer complete
//   bus_error  in   1  bus-unit access failed
//   done       out  3  completion pulse to the owner
//   err        out  3  error/timeout pulse to the owner
//   abort      out  1  one-cycle bus-unit abort on timeout
//   starved    out  1  some starvation counter is at STARVE_MAX
// ---------------------------------------------------------------------------
module bu_arbiter
   import bu_pkg::*;
#(
   parameter int STARVE_MAX  = 4,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   output logic [2:0] gnt,
   output logic [1:0] sel,
   output logic       bus_req,
   input  logic       trans_rdy,
   input  logic       bus_error,
   output logic [2:0] done,
   output logic [2:0] err,
   output logic       abort,
   output logic       starved
);

   localparam int              SW         = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

   bu_state_t  state_reg, state_next;
   logic [2:0] gnt_reg, gnt_next;
   logic [1:0] sel_reg, sel_next;
   logic       ptr_reg;
   logic [1:0] starve_flag;
   logic [2:0] pick_win;
   logic [1:0] pick_idx;
   logic       arb_fire;
   logic       timeout_hit;
   logic       abort_int;

   assign arb_fire = (state_reg == IDLE) && (|req);

   bu_rr_pick u_pick (
      .req    (req),
      .starve (starve_flag),
      .ptr    (ptr_reg),
      .win    (pick_win),
      .idx    (pick_idx)
   );

   // Starvation counters for I (gi=0) and PTW (gi=1); they only move at an
   // arbitration and saturate at STARVE_MAX.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_starve
         logic [SW-1:0] cnt_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (arb_fire) begin
               if (pick_win[gi+1]) begin
                  cnt_reg <= '0;
               end else if (req[gi+1] && (cnt_reg < STARVE_LIM)) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign starve_flag[gi] = (cnt_reg >= STARVE_LIM);
      end
   endgenerate

   // Pointer flips to the other non-D master after an I or PTW grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= 1'b0;
      end else if (arb_fire) begin
         if (pick_win[BU_REQ_I]) begin
            ptr_reg <= 1'b1;
         end else if (pick_win[BU_REQ_PTW]) begin
            ptr_reg <= 1'b0;
         end
      end
   end

`ifdef BU_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_cnt_reg;

   // The count includes the current grant cycle: the first GRANT cycle sees
   // 1, so the abort fires in grant cycle TIMEOUT_CYC.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_reg <= '0;
      end else if (arb_fire) begin
         tmo_cnt_reg <= TW'(1);
      end else if ((state_reg == GRANT) && (tmo_cnt_reg != TW'(TIMEOUT_CYC))) begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end

   assign timeout_hit = (state_reg == GRANT) && (tmo_cnt_reg == TW'(TIMEOUT_CYC));
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = 32'(TIMEOUT_CYC);
   assign timeout_hit        = 1'b0;
`endif

   // A real completion in the timeout cycle wins over the abort.
   assign abort_int = timeout_hit & ~trans_rdy & ~bus_error & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         gnt_reg   <= 3'b000;
         sel_reg   <= BU_REQ_D;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         sel_reg   <= sel_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      sel_next   = sel_reg;
      case (state_reg)
         IDLE: begin
            if (|req) begin
               state_next = GRANT;
               gnt_next   = pick_win;
               sel_next   = pick_idx;
            end
         end
         GRANT: begin
            // Dropping req does not end the grant; only the bus unit can.
            if (trans_rdy || bus_error || timeout_hit) begin
               state_next = RELEASE;
               gnt_next   = 3'b000;
               sel_next   = BU_REQ_D;
            end
         end
         RELEASE: begin
            state_next = IDLE;
            gnt_next   = 3'b000;
            sel_next   = BU_REQ_D;
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 3'b000;
            sel_next   = BU_REQ_D;
         end
      endcase
   end

   // gnt is zero outside GRANT, so bus-unit strobes in IDLE/RELEASE vanish.
   // rst masks the pulses so a transaction killed by reset never completes.
   assign done    = gnt_reg & {3{trans_rdy & ~bus_error & ~rst}};
   assign err     = gnt_reg & {3{(bus_error & ~rst) | abort_int}};
   assign abort   = abort_int;
   assign gnt     = gnt_reg;
   assign sel     = sel_reg;
   assign bus_req = |gnt_reg;
   assign starved = |starve_flag;

endmodule

// File: tb/tb_bu_arbiter.sv
module tb_bu_arbiter;

   logic       clk;
   logic       rst;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       bus_req;
   logic       trans_rdy;
   logic       bus_error;
   logic [2:0] done;
   logic [2:0] err;
   logic       abort;
   logic       starved;

   int errors = 0;
   int checks = 0;

   bu_arbiter #(
      .STARVE_MAX  (4),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .sel       (sel),
      .bus_req   (bus_req),
      .trans_rdy (trans_rdy),
      .bus_error (bus_error),
      .done      (done),
      .err       (err),
      .abort     (abort),
      .starved   (starved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0] req;
      logic       tr;
      logic       be;
      logic [2:0] gnt;
      logic [1:0] sel;
      logic [2:0] done;
      logic [2:0] err;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req       = 3'b000;
      trans_rdy = 1'b0;
      bus_error = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt",     32'(gnt),     32'h0);
      chk("rst_sel",     32'(sel),     32'h0);
      chk("rst_bus_req", 32'(bus_req), 32'h0);
      chk("rst_abort",   32'(abort),   32'h0);
      chk("rst_starved", 32'(starved), 32'h0);
      chk("rst_done",    32'(done),    32'h0);
      chk("rst_err",     32'(err),     32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int exp_own [20];
      bit exp_stv [20];

      rst       = 1'b1;
      req       = 3'b000;
      trans_rdy = 1'b0;
      bus_error = 1'b0;

      // cycle-by-cycle vectors: inputs held for the cycle, outputs expected in it
      vecs[0]  = '{3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[1]  = '{3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 3'b000, 3'b000};
      vecs[2]  = '{3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 3'b010, 3'b000};
      vecs[3]  = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[4]  = '{3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[5]  = '{3'b001, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[6]  = '{3'b001, 1'b1, 1'b1, 3'b001, 2'd0, 3'b000, 3'b001};
      vecs[7]  = '{3'b000, 1'b0, 1'b1, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[8]  = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[9]  = '{3'b100, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[10] = '{3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 3'b000, 3'b000};
      vecs[11] = '{3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 3'b000, 3'b000};
      vecs[12] = '{3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 3'b000, 3'b000};
      vecs[13] = '{3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 3'b000, 3'b000};
      vecs[14] = '{3'b000, 1'b0, 1'b0, 3'b100, 2'd2, 3'b000, 3'b000};
      vecs[15] = '{3'b000, 1'b1, 1'b0, 3'b100, 2'd2, 3'b100, 3'b000};
      vecs[16] = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[17] = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[18] = '{3'b110, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[19] = '{3'b110, 1'b1, 1'b0, 3'b010, 2'd1, 3'b010, 3'b000};
      vecs[20] = '{3'b110, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[21] = '{3'b110, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};
      vecs[22] = '{3'b110, 1'b1, 1'b0, 3'b100, 2'd2, 3'b100, 3'b000};
      vecs[23] = '{3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 3'b000};

      // req=111 held, 2-cycle transactions, clean counters and pointer
      exp_own = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 1};
      exp_stv = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};

      // ---------------- table-driven vectors ----------------
      reset_dut();
      for (int v = 0; v < 24; v++) begin
         @(posedge clk);
         #1;
         req       = vecs[v].req;
         trans_rdy = vecs[v].tr;
         bus_error = vecs[v].be;
         @(negedge clk);
         $display("vec %0d req=%b tr=%b be=%b gnt=%b sel=%0d done=%b err=%b",
                  v, req, trans_rdy, bus_error, gnt, sel, done, err);
         chk($sformatf("vec%0d_gnt", v),     32'(gnt),     32'(vecs[v].gnt));
         chk($sformatf("vec%0d_sel", v),     32'(sel),     32'(vecs[v].sel));
         chk($sformatf("vec%0d_bus_req", v), 32'(bus_req), 32'(|vecs[v].gnt));
         chk($sformatf("vec%0d_done", v),    32'(done),    32'(vecs[v].done));
         chk($sformatf("vec%0d_err", v),     32'(err),     32'(vecs[v].err));
      end

      // ---------------- starvation / round robin ----------------
      reset_dut();
      @(posedge clk);
      #1;
      req = 3'b111;
      for (int t = 0; t < 20; t++) begin
         logic [2:0] exp_oh;
         exp_oh = 3'b001 << exp_own[t];
         wait_grant(ok);
         chk($sformatf("stv%0d_grant_seen", t), 32'(ok), 32'h1);
         $display("txn %0d owner=%0d starved=%b", t, sel, starved);
         chk($sformatf("stv%0d_sel", t),     32'(sel),     32'(exp_own[t]));
         chk($sformatf("stv%0d_starved", t), 32'(starved), 32'(exp_stv[t]));
         @(posedge clk);
         #1;
         @(posedge clk);
         #1;
         trans_rdy = 1'b1;
         @(negedge clk);
         chk($sformatf("stv%0d_done", t), 32'(done), 32'(exp_oh));
         @(posedge clk);
         #1;
         trans_rdy = 1'b0;
      end
      req = 3'b000;

      // ---------------- timeout ----------------
      reset_dut();
      @(posedge clk);
      #1;
      req = 3'b001;
`ifdef BU_ARB_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         $display("tmo cycle %0d gnt=%b abort=%b err=%b", k, gnt, abort, err);
         chk($sformatf("tmo%0d_gnt", k),   32'(gnt),   32'h1);
         chk($sformatf("tmo%0d_abort", k), 32'(abort), (k == 8) ? 32'h1 : 32'h0);
         chk($sformatf("tmo%0d_err", k),   32'(err),   (k == 8) ? 32'h1 : 32'h0);
      end
      @(posedge clk);
      #1;
      req = 3'b000;
      @(negedge clk);
      chk("tmo_release_gnt",   32'(gnt),   32'h0);
      chk("tmo_release_abort", 32'(abort), 32'h0);
`else
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         $display("hold cycle %0d gnt=%b abort=%b err=%b", k, gnt, abort, err);
         chk($sformatf("hold%0d_gnt", k),   32'(gnt),   32'h1);
         chk($sformatf("hold%0d_abort", k), 32'(abort), 32'h0);
         chk($sformatf("hold%0d_err", k),   32'(err),   32'h0);
      end
      @(posedge clk);
      #1;
      trans_rdy = 1'b1;
      @(negedge clk);
      chk("hold_done", 32'(done), 32'h1);
      @(posedge clk);
      #1;
      trans_rdy = 1'b0;
      req       = 3'b000;
      @(negedge clk);
      chk("hold_release_gnt", 32'(gnt), 32'h0);
`endif

      // ---------------- reset during GRANT ----------------
      reset_dut();
      @(posedge clk);
      #1;
      req = 3'b100;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_pre_gnt", 32'(gnt), 32'h4);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      trans_rdy = 1'b1;
      @(negedge clk);
      $display("mid-grant reset gnt=%b done=%b err=%b", gnt, done, err);
      chk("mrst_done_in_rst", 32'(done), 32'h0);
      chk("mrst_err_in_rst",  32'(err),  32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 3'b000;
      @(negedge clk);
      $display("after reset gnt=%b sel=%0d done=%b", gnt, sel, done);
      chk("mrst_gnt",     32'(gnt),     32'h0);
      chk("mrst_sel",     32'(sel),     32'h0);
      chk("mrst_bus_req", 32'(bus_req), 32'h0);
      chk("mrst_done",    32'(done),    32'h0);
      chk("mrst_err",     32'(err),     32'h0);
      chk("mrst_abort",   32'(abort),   32'h0);
      chk("mrst_starved", 32'(starved), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mrst_stale_done", 32'(done), 32'h0);
      @(posedge clk);
      #1;
      trans_rdy = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bu_arbiter.md
# bu_arbiter

Three-way arbiter that shares the single L1 bus unit between the L1-D cache, the L1-I cache and the page-table walker (PTW). It grants one requester at a time, holds the grant until the bus unit reports completion or error, and routes completion and error pulses back to the owner. D has default priority, with starvation protection for I and PTW. It sits between the cache/PTW request ports and the bus-unit request mux, and drives that mux's select.

## Interface
Parameters:
- STARVE_MAX, 4: losing arbitrations after which a non-D requester is forced to win.
- TIMEOUT_CYC, 1023: grant cycles without completion before abort; used only with BU_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  3  level requests: bit0 = D, bit1 = I, bit2 = PTW. Held high until done/err.
- gnt  out  3  one-hot registered grant.
- sel  out  2  encoded owner: 0 = D, 1 = I, 2 = PTW. Equals 0 when idle.
- bus_req  out  1  equals |gnt; request qualifier to the bus unit.
- trans_rdy  in  1  bus-unit transfer complete.
- bus_error  in  1  bus-unit access failed.
- done  out  3  completion pulse to the owner.
- err  out  3  error pulse to the owner.
- abort  out  1  one-cycle bus-unit abort on timeout; tied to 0 without the macro.
- starved  out  1  high while any starvation counter is at STARVE_MAX.

## Operation
- FSM states are IDLE, GRANT and RELEASE.
- **IDLE**, when any req bit is high, arbitrate:
  - If req[1] or req[2] has a starvation counter ≥ STARVE_MAX, grant it. If both qualify, choose by the I/PTW round-robin pointer.
  - Otherwise, if req[0] is high, grant D.
  - Otherwise, grant I or PTW by the round-robin pointer.
  - Then go to GRANT.
- **GRANT**:
  - trans_rdy with no bus_error: done[owner] = 1.
  - bus_error: err[owner] = 1, and done is suppressed even if trans_rdy is also high.
  - Either event moves the FSM to RELEASE.
- **RELEASE**: gnt = 0 for one cycle so the owner can drop req. The FSM returns to IDLE unconditionally.
- **Starvation counters** (I and PTW, width clog2(STARVE_MAX+1)):
  - At each arbitration, increment (saturating) the counter of every requesting, non-granted master.
  - Clear a master's counter when it is granted.
- **Round-robin pointer** (1 bit, 0 = I next): after an I or PTW grant, points to the other one. It is unchanged by D grants.
- req dropping while granted does not release the grant. The bus transaction completes, and done/err are still pulsed.
- trans_rdy or bus_error seen in IDLE or RELEASE is ignored, with no pulse on done or err.
- done and err are combinational: gnt & trans_rdy, gnt & (bus_error | timeout).

## Timing
- Reset values:
  - gnt = 0, sel = 0, bus_req = 0, abort = 0, starved = 0.
  - done = 0, err = 0.
  - FSM = IDLE, counters = 0, pointer = 0.
- Grant latency: req high in IDLE at edge N gives gnt at N+1.
- Completion at cycle M:
  - done/err are high in cycle M.
  - gnt drops at M+1 (RELEASE).
  - Re-arbitration happens in IDLE at M+2; the earliest next gnt is M+3.
- Back-to-back transactions therefore take a minimum of 3 idle-grant cycles.
- Reset during GRANT: gnt clears at the next edge, and no done/err pulse is generated.

## Configuration
- **BU_ARB_TIMEOUT_EN defined**:
  - A counter of clog2(TIMEOUT_CYC+1) bits clears on entry to GRANT and counts every GRANT cycle.
  - When the count reaches TIMEOUT_CYC without completion: err[owner] = 1 and abort = 1 for one cycle, then the FSM goes to RELEASE.
  - A completion in the same cycle as the timeout wins: normal done/err, no abort.
- **BU_ARB_TIMEOUT_EN undefined**: no counter, abort = 0, and a grant waits indefinitely.

## Structure
- Shared package bu_pkg holds:
  - Requester index constants: BU_REQ_D = 0, BU_REQ_I = 1, BU_REQ_PTW = 2.
  - The state enum.
- Sub-module bu_rr_pick: combinational picker taking req, the starvation flags and the pointer, and returning a one-hot winner plus encoded index.

## Test plan
- Reset, then req = 3'b010 → gnt = 010 and sel = 1 next cycle. trans_rdy → done = 010 that cycle, gnt = 0 next cycle.
- req = 3'b111 held, each transaction completed after 2 cycles → D is granted 4 times, then I or PTW is forced with starved = 1. Over 20 transactions, both I and PTW are granted.
- trans_rdy and bus_error together during a D grant → err = 001, done = 000.
- Granted PTW drops req before completion → gnt is held. trans_rdy 5 cycles later → done = 100.
- With the macro and TIMEOUT_CYC = 8, no trans_rdy → at grant cycle 8, err[owner] = 1 and abort = 1 for one cycle. Without the macro, gnt stays high.
- rst asserted mid-GRANT → all outputs 0 next cycle, and a stale trans_rdy after reset produces no done.
